omp_iter_ctrl: RTL and testbench

//  Top-level iteration sequencer for the OMP-DRI reconstruction core. Copies y into the residual BRAM,

---
 rtl/omp_pkg.sv | 26 ++
 rtl/omp_support_set.sv | 46 ++++
 rtl/omp_iter_ctrl.sv | 178 +++++++++++++++++
 tb/tb_omp_iter_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omp_pkg.sv
// Shared sizes, FSM state encoding and error codes for the OMP-DRI iteration controller.
package omp_pkg;

  localparam int MAX_K    = 8;
  localparam int LAMBDA_W = 6;
  localparam int ROW_W    = 3;
  localparam int WDOG_W   = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_R,
    ST_INIT_FLUSH,
    ST_RUN_A,
    ST_CHECK,
    ST_RUN_B,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DUP     = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/omp_support_set.sv
// Support-set register file: append at cnt, clear, combinational read, and a parallel
// duplicate-hit flag over the valid entries [0..cnt-1].
module omp_support_set #(
  parameter int MAX_K    = 8,
  parameter int LAMBDA_W = 6,
  parameter int IDX_W    = $clog2(MAX_K),
  parameter int CNT_W    = $clog2(MAX_K + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                app,
  input  logic [LAMBDA_W-1:0] app_dat,
  input  logic [LAMBDA_W-1:0] chk_dat,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [LAMBDA_W-1:0] rd_dat,
  output logic [CNT_W-1:0]    cnt,
  output logic                dup
);
  import omp_pkg::*;

  logic [LAMBDA_W-1:0] mem [MAX_K];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < MAX_K; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
      for (int i = 0; i < MAX_K; i++) mem[i] <= '0;
    end else if (app && (cnt < CNT_W'(MAX_K))) begin
      mem[cnt[IDX_W-1:0]] <= app_dat;
      cnt                 <= cnt + CNT_W'(1);
    end
  end

  assign rd_dat = mem[rd_addr];

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < MAX_K; i++) begin
      if ((CNT_W'(i) < cnt) && (mem[i] == chk_dat)) dup = 1'b1;
    end
  end

endmodule

// File: rtl/omp_iter_ctrl.sv
// OMP-DRI iteration sequencer: copies y into r, then alternates Block A / Block B once per atom.
// Stages handshake with start/done pulses; a per-stage watchdog bounds each wait, abort returns to IDLE.
module omp_iter_ctrl #(
  parameter int MAX_K    = omp_pkg::MAX_K,
  parameter int LAMBDA_W = omp_pkg::LAMBDA_W,
  parameter int ROW_W    = omp_pkg::ROW_W,
  parameter int WDOG_W   = omp_pkg::WDOG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [LAMBDA_W-1:0] N,
  input  logic [ROW_W-1:0]    M,
  input  logic [3:0]          K,
  output logic [ROW_W-1:0]    y_addr,
  output logic                r_we,
  output logic [ROW_W-1:0]    r_wr_addr,
  output logic                r_sel,
  output logic                start_a,
  input  logic                a_done,
  input  logic [LAMBDA_W-1:0] lambda_in,
  output logic                start_b,
  output logic [LAMBDA_W-1:0] b_lambda,
  input  logic                b_done,
  input  logic                b_converged,
  input  logic [2:0]          supp_rd_addr,
  output logic [LAMBDA_W-1:0] supp_rd_data,
  output logic [3:0]          supp_cnt,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);
  import omp_pkg::*;

  // Last cycle a stage may wait: the transition out of it would make the counter reach 2^WDOG_W-1.
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_t              state, state_nxt;
  logic [LAMBDA_W-1:0] n_lat, lambda_q;
  logic [ROW_W-1:0]    m_lat, row_cnt;
  logic [3:0]          k_lat;
  logic [WDOG_W-1:0]   wdog;
  logic                conv_q;
  logic [1:0]          ecode_nxt;
  logic                supp_app, supp_clr, supp_dup;
  logic                wait_st;

  assign busy     = (state != ST_IDLE);
  assign wait_st  = (state == ST_RUN_A) || (state == ST_RUN_B);
  assign supp_clr = ((state == ST_IDLE) && start) || ((state != ST_IDLE) && abort);

  always_comb begin
    state_nxt = state;
    ecode_nxt = ERR_NONE;
    supp_app  = 1'b0;
    y_addr    = '0;
    r_sel     = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:       if (start) state_nxt = ST_INIT_R;
      ST_INIT_R: begin
        y_addr = row_cnt;
        if (row_cnt == m_lat) state_nxt = ST_INIT_FLUSH;
      end
      ST_INIT_FLUSH: state_nxt = (k_lat == '0) ? ST_DONE : ST_RUN_A;
      ST_RUN_A: begin
        start_a = (wdog == '0);
        if (a_done) begin
          state_nxt = ST_CHECK;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = ST_ERR;
          ecode_nxt = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (lambda_q > n_lat) begin
          state_nxt = ST_ERR;
          ecode_nxt = ERR_RANGE;
        end else if (supp_dup) begin
          state_nxt = ST_ERR;
          ecode_nxt = ERR_DUP;
        end else begin
          supp_app  = 1'b1;
          state_nxt = ST_RUN_B;
        end
      end
      ST_RUN_B: begin
        r_sel   = 1'b1;
        start_b = (wdog == '0);
        if (b_done) begin
          state_nxt = ST_NEXT;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = ST_ERR;
          ecode_nxt = ERR_TIMEOUT;
        end
      end
      ST_NEXT:  state_nxt = (conv_q || (supp_cnt == k_lat)) ? ST_DONE : ST_RUN_A;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything: no stage starts, no append, no completion.
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      ecode_nxt = ERR_NONE;
      supp_app  = 1'b0;
      start_a   = 1'b0;
      start_b   = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      n_lat     <= '0;
      m_lat     <= '0;
      k_lat     <= '0;
      row_cnt   <= '0;
      wdog      <= '0;
      lambda_q  <= '0;
      b_lambda  <= '0;
      conv_q    <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      r_we      <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      state     <= state_nxt;
      // y BRAM has one cycle of read latency, so the r write trails the address by a cycle.
      r_we      <= (state == ST_INIT_R) && !abort;
      r_wr_addr <= (state == ST_INIT_R) ? row_cnt : '0;
      if ((state == ST_IDLE) && start) begin
        n_lat    <= N;
        m_lat    <= M;
        k_lat    <= (K > 4'(MAX_K)) ? 4'(MAX_K) : K;
        row_cnt  <= '0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (state == ST_INIT_R) row_cnt <= row_cnt + 1'b1;
      wdog <= (wait_st && (state_nxt == state)) ? wdog + 1'b1 : '0;
      if ((state == ST_RUN_A) && a_done) lambda_q <= lambda_in;
      if ((state == ST_RUN_B) && b_done) conv_q <= b_converged;
      if (supp_app) b_lambda <= lambda_q;
      if ((state_nxt == ST_ERR) && (state != ST_ERR)) begin
        err      <= 1'b1;
        err_code <= ecode_nxt;
      end
    end
  end

  omp_support_set #(
    .MAX_K   (MAX_K),
    .LAMBDA_W(LAMBDA_W),
    .IDX_W   (3),
    .CNT_W   (4)
  ) u_supp (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (supp_clr),
    .app    (supp_app),
    .app_dat(lambda_q),
    .chk_dat(lambda_q),
    .rd_addr(supp_rd_addr),
    .rd_dat (supp_rd_data),
    .cnt    (supp_cnt),
    .dup    (supp_dup)
  );

endmodule

// File: tb/tb_omp_iter_ctrl.sv
// Directed bench for omp_iter_ctrl with a 4-bit watchdog; Block A/B are emulated by tasks.
module tb_omp_iter_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic       a_done = 1'b0, b_done = 1'b0, b_converged = 1'b0;
  logic [5:0] ni = '0, lambda_in = '0;
  logic [2:0] mi = '0, supp_rd_addr = '0;
  logic [3:0] ki = '0;
  logic [2:0] y_addr, r_wr_addr;
  logic       r_we, r_sel, start_a, start_b, busy, done, err;
  logic [5:0] b_lambda, supp_rd_data;
  logic [3:0] supp_cnt;
  logic [1:0] err_code;

  int checks = 0, errors = 0, tmo = 0;
  int n_sa = 0, n_sb = 0, n_done = 0, n_we = 0;
  int sa0, sb0, dn0, we0;
  logic [7:0] wr_xor = '0, xor0;

  omp_iter_ctrl #(.WDOG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .N(ni), .M(mi), .K(ki),
    .y_addr(y_addr), .r_we(r_we), .r_wr_addr(r_wr_addr), .r_sel(r_sel),
    .start_a(start_a), .a_done(a_done), .lambda_in(lambda_in),
    .start_b(start_b), .b_lambda(b_lambda), .b_done(b_done), .b_converged(b_converged),
    .supp_rd_addr(supp_rd_addr), .supp_rd_data(supp_rd_data), .supp_cnt(supp_cnt),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_a) n_sa++;
    if (start_b) n_sb++;
    if (done) n_done++;
    if (r_we) begin
      n_we++;
      wr_xor = wr_xor ^ (8'd1 << r_wr_addr);
    end
  end

  task automatic mark();
    sa0 = n_sa; sb0 = n_sb; dn0 = n_done; we0 = n_we; xor0 = wr_xor;
  endtask

  task automatic kick(input logic [5:0] n, input logic [2:0] m, input logic [3:0] k);
    @(negedge clk);
    ni = n; mi = m; ki = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // which: 0 start_a, 1 start_b, 2 done, 3 err
  task automatic wait_sig(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((which == 0 && start_a) || (which == 1 && start_b) ||
          (which == 2 && done) || (which == 3 && err)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) tmo++;
  endtask

  task automatic serve_a(input logic [5:0] lam);
    bit ok;
    wait_sig(0, ok);
    if (ok) begin
      a_done = 1'b1; lambda_in = lam;
      @(negedge clk);
      a_done = 1'b0;
    end
  endtask

  task automatic serve_b(input logic conv, output logic [5:0] bl);
    bit ok;
    bl = '1;
    wait_sig(1, ok);
    if (ok) begin
      bl = b_lambda;
      b_done = 1'b1; b_converged = conv;
      @(negedge clk);
      b_done = 1'b0; b_converged = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, err_code, r_we, r_sel, start_a, start_b, y_addr, supp_cnt, b_lambda} !== '0) begin
      errors++; $display("FAIL reset_outputs got busy=%b done=%b err=%b code=%0d cnt=%0d", busy, done, err, err_code, supp_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, err, supp_rd_data} !== '0) begin
      errors++; $display("FAIL reset_release got busy=%b err=%b rd=%0d exp 0", busy, err, supp_rd_data);
    end
  endtask

  task automatic test_basic();
    logic [5:0] bl;
    bit ok;
    mark();
    kick(6'd15, 3'd1, 4'd2);
    checks++;
    if ({busy, r_we, y_addr} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL basic_init0 got busy=%b we=%b y=%0d exp 1 0 0", busy, r_we, y_addr);
    end
    @(negedge clk);
    checks++;
    if ({r_we, r_wr_addr, y_addr, r_sel} !== {1'b1, 3'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL basic_init1 got we=%b wa=%0d y=%0d sel=%b exp 1 0 1 0", r_we, r_wr_addr, y_addr, r_sel);
    end
    @(negedge clk);
    checks++;
    if ({r_we, r_wr_addr} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL basic_flush got we=%b wa=%0d exp 1 1", r_we, r_wr_addr);
    end
    serve_a(6'd5);
    serve_b(1'b0, bl);
    checks++;
    if (bl !== 6'd5) begin errors++; $display("FAIL basic_blambda0 got %0d exp 5", bl); end
    serve_a(6'd9);
    serve_b(1'b0, bl);
    checks++;
    if (bl !== 6'd9) begin errors++; $display("FAIL basic_blambda1 got %0d exp 9", bl); end
    wait_sig(2, ok);
    @(negedge clk);
    supp_rd_addr = 3'd0;
    #1;
    checks++;
    if (supp_rd_data !== 6'd5) begin errors++; $display("FAIL basic_supp0 got %0d exp 5", supp_rd_data); end
    supp_rd_addr = 3'd1;
    #1;
    checks++;
    if (supp_rd_data !== 6'd9) begin errors++; $display("FAIL basic_supp1 got %0d exp 9", supp_rd_data); end
    checks++;
    if ({busy, supp_cnt} !== {1'b0, 4'd2}) begin
      errors++; $display("FAIL basic_end got busy=%b cnt=%0d exp 0 2", busy, supp_cnt);
    end
    checks++;
    if (n_done - dn0 != 1 || n_sa - sa0 != 2 || n_sb - sb0 != 2 || n_we - we0 != 2 || (wr_xor ^ xor0) !== 8'h03) begin
      errors++; $display("FAIL basic_counts got done=%0d sa=%0d sb=%0d we=%0d exp 1 2 2 2", n_done - dn0, n_sa - sa0, n_sb - sb0, n_we - we0);
    end
  endtask

  task automatic test_full();
    logic [5:0] bl;
    bit ok;
    mark();
    kick(6'd63, 3'd7, 4'd8);
    for (int i = 0; i < 8; i++) begin
      serve_a(6'(7 * i));
      if (i == 7) begin
        checks++;
        if (n_done - dn0 != 0) begin errors++; $display("FAIL full_early_done got %0d exp 0", n_done - dn0); end
      end
      serve_b(1'b0, bl);
    end
    wait_sig(2, ok);
    @(negedge clk);
    supp_rd_addr = 3'd7;
    #1;
    checks++;
    if ({supp_cnt, supp_rd_data} !== {4'd8, 6'd49}) begin
      errors++; $display("FAIL full_supp got cnt=%0d s7=%0d exp 8 49", supp_cnt, supp_rd_data);
    end
    checks++;
    if (n_done - dn0 != 1 || n_sa - sa0 != 8 || n_sb - sb0 != 8 || n_we - we0 != 8 || (wr_xor ^ xor0) !== 8'hFF) begin
      errors++; $display("FAIL full_counts got done=%0d sa=%0d sb=%0d we=%0d exp 1 8 8 8", n_done - dn0, n_sa - sa0, n_sb - sb0, n_we - we0);
    end
  endtask

  task automatic test_dup();
    logic [5:0] bl;
    bit ok;
    mark();
    kick(6'd15, 3'd1, 4'd3);
    serve_a(6'd12);
    serve_b(1'b0, bl);
    serve_a(6'd12);
    wait_sig(3, ok);
    checks++;
    if ({err, err_code, supp_cnt} !== {1'b1, 2'd1, 4'd1}) begin
      errors++; $display("FAIL dup_err got err=%b code=%0d cnt=%0d exp 1 1 1", err, err_code, supp_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_sb - sb0 != 1 || n_done - dn0 != 0) begin
      errors++; $display("FAIL dup_after got busy=%b sb=%0d done=%0d exp 0 1 0", busy, n_sb - sb0, n_done - dn0);
    end
  endtask

  task automatic test_range();
    logic [5:0] bl;
    bit ok;
    mark();
    kick(6'd15, 3'd1, 4'd2);
    serve_a(6'd20);
    wait_sig(3, ok);
    repeat (3) @(negedge clk);
    checks++;
    if ({err, err_code, busy} !== {1'b1, 2'd2, 1'b0} || n_sb - sb0 != 0) begin
      errors++; $display("FAIL range_err got err=%b code=%0d busy=%b sb=%0d exp 1 2 0 0", err, err_code, busy, n_sb - sb0);
    end
    mark();
    kick(6'd15, 3'd1, 4'd1);
    checks++;
    if ({err, err_code} !== 3'b000) begin
      errors++; $display("FAIL range_restart_clear got err=%b code=%0d exp 0 0", err, err_code);
    end
    serve_a(6'd15);
    serve_b(1'b0, bl);
    wait_sig(2, ok);
    supp_rd_addr = 3'd0;
    @(negedge clk);
    checks++;
    if ({supp_cnt, supp_rd_data, err} !== {4'd1, 6'd15, 1'b0} || n_done - dn0 != 1) begin
      errors++; $display("FAIL range_restart got cnt=%0d s0=%0d err=%b done=%0d exp 1 15 0 1", supp_cnt, supp_rd_data, err, n_done - dn0);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int cyc;
    mark();
    kick(6'd15, 3'd1, 4'd1);
    wait_sig(0, ok);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (err) break;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != 15 || err_code !== 2'd3) begin
      errors++; $display("FAIL wdog_timeout got cycles=%0d code=%0d exp 15 3", cyc, err_code);
    end
    @(negedge clk);
    a_done = 1'b1; lambda_in = 6'd2;
    @(negedge clk);
    a_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, err, err_code, supp_cnt} !== {1'b0, 1'b1, 2'd3, 4'd0} || n_sb - sb0 != 0) begin
      errors++; $display("FAIL wdog_late_done got busy=%b err=%b code=%0d cnt=%0d exp 0 1 3 0", busy, err, err_code, supp_cnt);
    end
  endtask

  task automatic test_abort();
    logic [5:0] bl;
    bit ok;
    mark();
    kick(6'd15, 3'd1, 4'd3);
    serve_a(6'd4);
    serve_b(1'b0, bl);
    wait_sig(0, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, supp_cnt, err} !== {1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL abort_idle got busy=%b cnt=%0d err=%b exp 0 0 0", busy, supp_cnt, err);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_done - dn0 != 0 || n_sb - sb0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_after got done=%0d sb=%0d busy=%b exp 0 1 0", n_done - dn0, n_sb - sb0, busy);
    end
  endtask

  task automatic test_conv_reset();
    logic [5:0] bl;
    bit ok;
    mark();
    kick(6'd15, 3'd1, 4'd4);
    serve_a(6'd6);
    serve_b(1'b1, bl);
    wait_sig(2, ok);
    @(negedge clk);
    checks++;
    if ({busy, supp_cnt} !== {1'b0, 4'd1} || n_done - dn0 != 1 || n_sa - sa0 != 1) begin
      errors++; $display("FAIL conv_done got busy=%b cnt=%0d done=%0d sa=%0d exp 0 1 1 1", busy, supp_cnt, n_done - dn0, n_sa - sa0);
    end
    kick(6'd15, 3'd1, 4'd4);
    serve_a(6'd6);
    wait_sig(1, ok);
    supp_rd_addr = 3'd0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, r_sel, start_b, start_a, done, err, err_code, r_we, y_addr, supp_cnt, b_lambda, supp_rd_data} !== '0) begin
      errors++; $display("FAIL conv_async_reset got busy=%b sel=%b sb=%b cnt=%0d bl=%0d rd=%0d exp all 0", busy, r_sel, start_b, supp_cnt, b_lambda, supp_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL conv_post_reset got busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_dup();
    test_range();
    test_watchdog();
    test_abort();
    test_conv_reset();
    checks++;
    if (tmo != 0) begin errors++; $display("FAIL handshake_timeouts got %0d exp 0", tmo); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
